// File: rtl/vec_pkg.sv
// rtl/vec_pkg.sv - shared sizes, op encodings and FSM state type for vector_alu
package vec_pkg;

  localparam int ELEM_W   = 32;
  localparam int NUM_ELEM = 16;
  localparam int VEC_W    = ELEM_W * NUM_ELEM;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_MULLO = 2'b10;
  localparam logic [1:0] OP_MULHI = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/vector_alu_lane.sv
// rtl/vector_alu_lane.sv - single-element combinational ALU lane; VEC_ALU_SAT_EN selects saturating signed add/sub
module vector_alu_lane #(
  parameter int ELEM_W = vec_pkg::ELEM_W
) (
  input  logic [1:0]        i_op,
  input  logic [ELEM_W-1:0] i_a,
  input  logic [ELEM_W-1:0] i_b,
  output logic [ELEM_W-1:0] o_y
);
  import vec_pkg::*;

  logic [2*ELEM_W-1:0] w_prod;
  logic [ELEM_W-1:0]   w_sum;
  logic [ELEM_W-1:0]   w_diff;
  logic [ELEM_W-1:0]   w_add_res;
  logic [ELEM_W-1:0]   w_sub_res;

  assign w_prod = {{ELEM_W{1'b0}}, i_a} * {{ELEM_W{1'b0}}, i_b};
  assign w_sum  = i_a + i_b;
  assign w_diff = i_a - i_b;

`ifdef VEC_ALU_SAT_EN
  logic              w_add_ovf;
  logic              w_sub_ovf;
  logic [ELEM_W-1:0] w_sat_val;

  // Overflow only happens when the result sign disagrees with operand A's sign;
  // the clamp direction therefore follows A's sign.
  assign w_add_ovf = (i_a[ELEM_W-1] == i_b[ELEM_W-1]) && (w_sum[ELEM_W-1]  != i_a[ELEM_W-1]);
  assign w_sub_ovf = (i_a[ELEM_W-1] != i_b[ELEM_W-1]) && (w_diff[ELEM_W-1] != i_a[ELEM_W-1]);
  assign w_sat_val = i_a[ELEM_W-1] ? {1'b1, {(ELEM_W-1){1'b0}}} : {1'b0, {(ELEM_W-1){1'b1}}};
  assign w_add_res = w_add_ovf ? w_sat_val : w_sum;
  assign w_sub_res = w_sub_ovf ? w_sat_val : w_diff;
`else
  assign w_add_res = w_sum;
  assign w_sub_res = w_diff;
`endif

  // Select the lane result by operation
  always_comb begin
    o_y = w_add_res;
    case (i_op)
      OP_ADD:   o_y = w_add_res;
      OP_SUB:   o_y = w_sub_res;
      OP_MULLO: o_y = w_prod[ELEM_W-1:0];
      OP_MULHI: o_y = w_prod[2*ELEM_W-1:ELEM_W];
      default:  o_y = w_add_res;
    endcase
  end

endmodule

// File: rtl/vector_alu.sv
// rtl/vector_alu.sv - multi-cycle vector ALU, LANES elements per cycle; optional VEC_ALU_SAT_EN
module vector_alu #(
  parameter int ELEM_W   = vec_pkg::ELEM_W,
  parameter int NUM_ELEM = vec_pkg::NUM_ELEM,
  parameter int LANES    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 alu_op,
  input  logic [ELEM_W*NUM_ELEM-1:0] src_a,
  input  logic [ELEM_W*NUM_ELEM-1:0] src_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ELEM_W*NUM_ELEM-1:0] result,
  output logic                       busy
);
  import vec_pkg::*;

  localparam int NCHUNK = NUM_ELEM / LANES;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

  if (NUM_ELEM % LANES != 0) begin : g_lanes_check
    $error("vector_alu: NUM_ELEM must be a multiple of LANES");
  end

  state_t            r_state;
  logic [1:0]        r_op;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_out_valid;
  logic              r_busy;
  logic [ELEM_W-1:0] r_a   [NCHUNK][LANES];
  logic [ELEM_W-1:0] r_b   [NCHUNK][LANES];
  logic [ELEM_W-1:0] r_res [NCHUNK][LANES];

  logic [ELEM_W-1:0] w_a_lane [LANES];
  logic [ELEM_W-1:0] w_b_lane [LANES];
  logic [ELEM_W-1:0] w_y_lane [LANES];

  // Chunk mux: present the captured operands of the current chunk to the lanes
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_a_lane[l] = r_a[r_cnt][l];
      w_b_lane[l] = r_b[r_cnt][l];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    vector_alu_lane #(.ELEM_W(ELEM_W)) u_lane (
      .i_op (r_op),
      .i_a  (w_a_lane[g]),
      .i_b  (w_b_lane[g]),
      .o_y  (w_y_lane[g])
    );
  end

  // Control FSM with operand capture, chunk write-back and registered status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_op        <= OP_ADD;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      for (int c = 0; c < NCHUNK; c++) begin
        for (int l = 0; l < LANES; l++) begin
          r_a[c][l]   <= '0;
          r_b[c][l]   <= '0;
          r_res[c][l] <= '0;
        end
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_op  <= alu_op;
            r_cnt <= '0;
            for (int c = 0; c < NCHUNK; c++) begin
              for (int l = 0; l < LANES; l++) begin
                r_a[c][l] <= src_a[(c*LANES+l)*ELEM_W +: ELEM_W];
                r_b[c][l] <= src_b[(c*LANES+l)*ELEM_W +: ELEM_W];
              end
            end
            r_busy  <= 1'b1;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          for (int l = 0; l < LANES; l++) begin
            r_res[r_cnt][l] <= w_y_lane[l];
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_CHUNK) begin
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  // Flatten the chunked result store onto the packed output vector
  always_comb begin
    result = '0;
    for (int c = 0; c < NCHUNK; c++) begin
      for (int l = 0; l < LANES; l++) begin
        result[(c*LANES+l)*ELEM_W +: ELEM_W] = r_res[c][l];
      end
    end
  end

  assign in_ready  = (r_state == IDLE) && !rst;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;

endmodule

// File: tb/tb_vector_alu.sv
// tb/tb_vector_alu.sv - self-checking bench for vector_alu; honours VEC_ALU_SAT_EN
module tb_vector_alu;
  import vec_pkg::*;

  localparam int LANES  = 4;
  localparam int NCHUNK = NUM_ELEM / LANES;
  localparam int LAT    = NCHUNK + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       alu_op;
  logic [VEC_W-1:0] src_a;
  logic [VEC_W-1:0] src_b;
  logic             out_valid;
  logic             out_ready;
  logic [VEC_W-1:0] result;
  logic             busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vector_alu #(.ELEM_W(ELEM_W), .NUM_ELEM(NUM_ELEM), .LANES(LANES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  typedef struct {
    logic [1:0]       op;
    logic [VEC_W-1:0] a;
    logic [VEC_W-1:0] b;
    logic [VEC_W-1:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic chk_vec(input string name, input logic [VEC_W-1:0] got, input logic [VEC_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VEC_W-1:0] splat(input logic [ELEM_W-1:0] v);
    logic [VEC_W-1:0] r;
    for (int i = 0; i < NUM_ELEM; i++) r[i*ELEM_W +: ELEM_W] = v;
    return r;
  endfunction

  function automatic logic [ELEM_W-1:0] rand_elem();
    logic [ELEM_W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = ELEM_W'(1);
      2:       v = {1'b0, {(ELEM_W-1){1'b1}}};
      3:       v = {1'b1, {(ELEM_W-1){1'b0}}};
      4:       v = '1;
      default: v = ELEM_W'($urandom);
    endcase
    return v;
  endfunction

  function automatic logic [VEC_W-1:0] rand_vec();
    logic [VEC_W-1:0] r;
    for (int i = 0; i < NUM_ELEM; i++) r[i*ELEM_W +: ELEM_W] = rand_elem();
    return r;
  endfunction

  // Reference: per element arithmetic on wide integers, then wrap or clamp
  function automatic logic [VEC_W-1:0] model(input logic [1:0] op, input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b);
    logic [VEC_W-1:0] r;
    longint           smax;
    longint           smin;
    smax = (longint'(1) <<< (ELEM_W - 1)) - 1;
    smin = -(longint'(1) <<< (ELEM_W - 1));
    r = '0;
    for (int i = 0; i < NUM_ELEM; i++) begin
      longint unsigned ua;
      longint unsigned ub;
      longint unsigned p;
      longint          sa;
      longint          sb;
      longint          s;
      ua = 64'(a[i*ELEM_W +: ELEM_W]);
      ub = 64'(b[i*ELEM_W +: ELEM_W]);
      sa = longint'($signed(a[i*ELEM_W +: ELEM_W]));
      sb = longint'($signed(b[i*ELEM_W +: ELEM_W]));
      p  = ua * ub;
      s  = (op == OP_SUB) ? (sa - sb) : (sa + sb);
`ifdef VEC_ALU_SAT_EN
      if (s > smax) s = smax;
      if (s < smin) s = smin;
`endif
      if (op == OP_MULLO)      r[i*ELEM_W +: ELEM_W] = p[ELEM_W-1:0];
      else if (op == OP_MULHI) r[i*ELEM_W +: ELEM_W] = p[2*ELEM_W-1:ELEM_W];
      else                     r[i*ELEM_W +: ELEM_W] = s[ELEM_W-1:0];
    end
    return r;
  endfunction

  task automatic add_vec(input logic [1:0] op, input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b, input logic [VEC_W-1:0] exp);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.exp = exp;
    tbl.push_back(v);
  endtask

  // Handshake one operation, scramble inputs during EXEC, check latency/busy/result
  task automatic do_op(input string tag, input logic [1:0] op, input logic [VEC_W-1:0] a,
                       input logic [VEC_W-1:0] b, input logic [VEC_W-1:0] exp, input bit release_out);
    int w;
    int lat;
    int busy_ok;
    int rdy_low;
    w = 0;
    while (!in_ready && w < 20) begin step(); w++; end
    chk_int({tag, " in_ready before accept"}, int'(in_ready), 1);
    in_valid = 1'b1; alu_op = op; src_a = a; src_b = b;
    step();
    lat = 1; busy_ok = 1; rdy_low = 1;
    while (!out_valid && lat < 3 * LAT) begin
      if (!busy) busy_ok = 0;
      if (in_ready) rdy_low = 0;
      src_a     = rand_vec();
      src_b     = rand_vec();
      alu_op    = 2'($urandom);
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      step();
      lat++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk_int({tag, " latency"}, lat, LAT);
    chk_int({tag, " busy during exec"}, busy_ok, 1);
    chk_int({tag, " in_ready low during exec"}, rdy_low, 1);
    chk_int({tag, " busy in done"}, int'(busy), 1);
    chk_vec({tag, " result"}, result, exp);
    if (release_out) begin
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk_int({tag, " out_valid after release"}, int'(out_valid), 0);
      chk_int({tag, " in_ready after release"}, int'(in_ready), 1);
      chk_vec({tag, " result held in idle"}, result, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [VEC_W-1:0] a;
    logic [VEC_W-1:0] b;
    logic [VEC_W-1:0] e;
    logic [1:0]       op;
    int               stable;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; alu_op = OP_ADD;
    src_a = '0; src_b = '0;

    // Reset state
    step(); step();
    chk_int("in_ready during reset", int'(in_ready), 0);
    rst = 1'b0;
    #1;
    chk_int("reset out_valid", int'(out_valid), 0);
    chk_int("reset busy", int'(busy), 0);
    chk_vec("reset result", result, '0);
    chk_int("in_ready after reset", int'(in_ready), 1);

    // Directed table
    for (int i = 0; i < NUM_ELEM; i++) begin
      a[i*ELEM_W +: ELEM_W] = 32'h1;
      b[i*ELEM_W +: ELEM_W] = ELEM_W'(i);
      e[i*ELEM_W +: ELEM_W] = ELEM_W'(i + 1);
    end
    add_vec(OP_ADD, a, b, e);
`ifdef VEC_ALU_SAT_EN
    add_vec(OP_SUB,   splat(32'h80000000), splat(32'h1), splat(32'h80000000));
    add_vec(OP_ADD,   splat(32'h7FFFFFFF), splat(32'h1), splat(32'h7FFFFFFF));
    add_vec(OP_SUB,   splat(32'h7FFFFFFF), splat(32'hFFFFFFFF), splat(32'h7FFFFFFF));
`else
    add_vec(OP_SUB,   splat(32'h0), splat(32'h1), splat(32'hFFFFFFFF));
    add_vec(OP_ADD,   splat(32'h7FFFFFFF), splat(32'h1), splat(32'h80000000));
    add_vec(OP_SUB,   splat(32'h7FFFFFFF), splat(32'hFFFFFFFF), splat(32'h80000000));
`endif
    add_vec(OP_ADD,   splat(32'hFFFFFFFF), splat(32'h1), splat(32'h0));
    add_vec(OP_MULLO, splat(32'hFFFFFFFF), splat(32'h2), splat(32'hFFFFFFFE));
    add_vec(OP_MULHI, splat(32'hFFFFFFFF), splat(32'h2), splat(32'h00000001));
    add_vec(OP_MULLO, splat(32'hFFFFFFFF), splat(32'hFFFFFFFF), splat(32'h00000001));
    add_vec(OP_MULHI, splat(32'hFFFFFFFF), splat(32'hFFFFFFFF), splat(32'hFFFFFFFE));
    add_vec(OP_MULHI, splat(32'h00010000), splat(32'h00010000), splat(32'h00000001));

    for (int i = 0; i < tbl.size(); i++) begin
      do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, 1'b1);
    end

    // Backpressure: hold DONE for 10 cycles with an in_valid pulse in the window
    a = rand_vec(); b = rand_vec();
    e = model(OP_MULLO, a, b);
    do_op("bp", OP_MULLO, a, b, e, 1'b0);
    stable = 1;
    for (int k = 0; k < 10; k++) begin
      in_valid = (k == 3 || k == 4);
      src_a    = rand_vec();
      src_b    = rand_vec();
      alu_op   = OP_ADD;
      if (in_ready) stable = 0;
      step();
      if (!out_valid || !busy || in_ready || result !== e) stable = 0;
    end
    in_valid = 1'b0;
    chk_int("bp done held stable", stable, 1);
    chk_vec("bp result after hold", result, e);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk_int("bp out_valid after release", int'(out_valid), 0);
    chk_int("bp in_ready after release", int'(in_ready), 1);
    a = rand_vec(); b = rand_vec();
    do_op("bp next", OP_SUB, a, b, model(OP_SUB, a, b), 1'b1);

    // Reset after chunk 2 has been written
    a = rand_vec(); b = rand_vec();
    in_valid = 1'b1; alu_op = OP_ADD; src_a = a; src_b = b;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_int("midreset out_valid", int'(out_valid), 0);
    chk_int("midreset busy", int'(busy), 0);
    chk_vec("midreset result", result, '0);
    stable = 1;
    for (int k = 0; k < 8; k++) begin
      step();
      if (out_valid) stable = 0;
    end
    chk_int("midreset no result produced", stable, 1);
    a = rand_vec(); b = rand_vec();
    do_op("post reset add", OP_ADD, a, b, model(OP_ADD, a, b), 1'b1);

    // Randomized operations against the reference model
    for (int n = 0; n < 24; n++) begin
      op = 2'($urandom);
      a  = rand_vec();
      b  = rand_vec();
      do_op($sformatf("rand%0d", n), op, a, b, model(op, a, b), 1'b1);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
